uart_cfg_rx: RTL and testbench



---
 rtl/uart_cfg_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_cfg_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_rx.sv
// UART receiver that collects PAR_NUM words into a staging bank and commits
// them atomically to cfg_data once a complete, error-free packet has arrived.
module uart_cfg_rx #(
  parameter int CLKS_PER_BIT = 52,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int PAR_NUM      = 5,
  parameter int IDLE_TIMEOUT = 1040
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           uart_data,
  output logic [PAR_NUM*DATA_BITS-1:0]   cfg_data,
  output logic                           cfg_valid,
  output logic                           byte_valid,
  output logic                           frame_err,
  output logic                           parity_err,
  output logic [2:0]                     dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int IW = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int WW = PAR_NUM * DATA_BITS;

  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAR_NUM - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD_PAR  = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q, prev_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic [TW-1:0]          tmo_q;
  logic [IW-1:0]          idx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_ok_q;
  logic [WW-1:0]          stage_q, stage_d;
  logic [WW-1:0]          cfg_data_q;
  logic                   cfg_valid_q, byte_valid_q, frame_err_q, parity_err_q;
  logic                   fall;

  assign fall        = prev_q & ~sync2_q;
  assign cfg_data    = cfg_data_q;
  assign cfg_valid   = cfg_valid_q;
  assign byte_valid  = byte_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign dbg_state_o = state_q;

  // Synchroniser and edge history idle high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    stage_d = stage_q;
    stage_d[idx_q*DATA_BITS +: DATA_BITS] = shreg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      tmo_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_ok_q     <= 1'b1;
      stage_q      <= '0;
      cfg_data_q   <= '0;
      cfg_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      cfg_valid_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (idx_q != '0) begin
            if (tmo_q == TMO_MAX) begin
              idx_q <= '0;
              tmo_q <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end else begin
            tmo_q <= '0;
          end
          // A start edge wins over the timeout reset of tmo_q but keeps its idx clear.
          if (fall) begin
            state_q  <= S_START;
            cnt_q    <= HALF_BIT;
            par_ok_q <= 1'b1;
            tmo_q    <= '0;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (!sync2_q) begin
              state_q <= S_DATA;
              cnt_q   <= FULL_BIT;
              bit_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shreg_q <= {sync2_q, shreg_q[DATA_BITS-1:1]};
            cnt_q   <= FULL_BIT;
            if (bit_q == BIT_LAST) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == '0) begin
            par_ok_q <= (sync2_q == ((^shreg_q) ^ ODD_PAR));
            cnt_q    <= FULL_BIT;
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (!sync2_q) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
              state_q     <= S_WAIT_HIGH;
            end else if (!par_ok_q) begin
              parity_err_q <= 1'b1;
              idx_q        <= '0;
              state_q      <= S_IDLE;
            end else begin
              byte_valid_q <= 1'b1;
              stage_q      <= stage_d;
              state_q      <= S_IDLE;
              if (idx_q == IDX_LAST) begin
                cfg_data_q  <= stage_d;
                cfg_valid_q <= 1'b1;
                idx_q       <= '0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (sync2_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Bench for uart_cfg_rx: one no-parity and one odd-parity instance driven by
// serial frame tasks, checked by a packet-level model and an event scoreboard.
module tb_uart_cfg_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int PN  = 3;
  localparam int TO  = 1040;
  localparam int W   = PN * DW;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic [W-1:0] cfg0, cfg1;
  logic cv0, bv0, fe0, pe0, cv1, bv1, fe1, pe1;
  logic [2:0] st0, st1;

  uart_cfg_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(0), .PAR_NUM(PN), .IDLE_TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst0), .uart_data(rx0), .cfg_data(cfg0), .cfg_valid(cv0),
    .byte_valid(bv0), .frame_err(fe0), .parity_err(pe0), .dbg_state_o(st0));

  uart_cfg_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(2), .PAR_NUM(PN), .IDLE_TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst1), .uart_data(rx1), .cfg_data(cfg1), .cfg_valid(cv1),
    .byte_valid(bv1), .frame_err(fe1), .parity_err(pe1), .dbg_state_o(st1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event codes {parity_err, frame_err, byte_valid}; one-hot per received frame.
  logic [2:0]   ev_q0[$], ev_q1[$];
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int           m_idx[2];
  logic [DW-1:0] m_stage[2][PN];
  logic [W-1:0] m_cfg[2];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic [2:0] ev, input logic cv, input logic [W-1:0] cfg);
    logic [2:0]   e;
    logic [W-1:0] c;
    if (ev != 3'b000) begin
      e = 3'b000;
      if (d == 0 && ev_q0.size() > 0) e = ev_q0.pop_front();
      if (d == 1 && ev_q1.size() > 0) e = ev_q1.pop_front();
      check($sformatf("dut%0d_event", d), W'(ev), W'(e));
    end
    if (cv) begin
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        check($sformatf("dut%0d_unexpected_cfg_valid", d), W'(1), W'(0));
      end else begin
        c = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("dut%0d_cfg_data", d), cfg, c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst0) mon(0, {pe0, fe0, bv0}, cv0, cfg0);
    if (!rst1) mon(1, {pe1, fe1, bv1}, cv1, cfg1);
  end

  task automatic model_reset(input int d);
    m_idx[d] = 0;
    m_cfg[d] = '0;
    for (int k = 0; k < PN; k++) m_stage[d][k] = '0;
  endtask

  task automatic model_frame(input int d, input logic [DW-1:0] b, input bit bad_par, input bit bad_stop);
    logic [2:0] e;
    e = bad_stop ? 3'b010 : (bad_par ? 3'b100 : 3'b001);
    if (d == 0) ev_q0.push_back(e); else ev_q1.push_back(e);
    if (e != 3'b001) begin
      m_idx[d] = 0;
    end else begin
      m_stage[d][m_idx[d]] = b;
      if (m_idx[d] == PN - 1) begin
        for (int k = 0; k < PN; k++) m_cfg[d][k*DW +: DW] = m_stage[d][k];
        if (d == 0) exp_q0.push_back(m_cfg[d]); else exp_q1.push_back(m_cfg[d]);
        m_idx[d] = 0;
      end else begin
        m_idx[d]++;
      end
    end
  endtask

  task automatic set_line(input int d, input logic v);
    if (d == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic hold(input int d, input logic v, input int n);
    set_line(d, v);
    repeat (n) @(negedge clk);
  endtask

  // gap: extra idle-high clocks after the stop bit; stop_low: bit times the stop bit is held low.
  task automatic send(input int d, input logic [DW-1:0] b, input bit bad_par, input int stop_low, input int gap);
    model_frame(d, b, bad_par, stop_low != 0);
    hold(d, 1'b0, CPB);
    for (int i = 0; i < DW; i++) hold(d, b[i], CPB);
    if (d == 1) hold(d, (^b) ^ 1'b1 ^ bad_par, CPB);
    if (stop_low > 0) hold(d, 1'b0, CPB * stop_low);
    hold(d, 1'b1, CPB + gap);
    if (gap >= TO + 5) m_idx[d] = 0;
  endtask

  task automatic rand_run(input int d, input int n);
    logic [DW-1:0] b;
    int r, sl, gap;
    bit bp;
    for (int i = 0; i < n; i++) begin
      b   = DW'($urandom_range(0, 255));
      r   = $urandom_range(0, 9);
      bp  = (d == 1) && (r == 0);
      sl  = (r == 1) ? $urandom_range(1, 3) : 0;
      gap = ($urandom_range(0, 7) == 0) ? TO + 5 + $urandom_range(0, 40) : $urandom_range(0, 120);
      send(d, b, bp, sl, gap);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    check("reset_cfg0", cfg0, '0);
    check("reset_cfg1", cfg1, '0);
    check("reset_pulses0", W'({cv0, bv0, fe0, pe0}), '0);
    check("reset_pulses1", W'({cv1, bv1, fe1, pe1}), '0);
    check("reset_state0", W'(st0), '0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (5) @(negedge clk);

    fork
      begin
        send(0, 8'h12, 0, 0, 0);
        send(0, 8'h34, 0, 0, 0);
        send(0, 8'h56, 0, 0, 20);
        check("b2b_packet", cfg0, 24'h563412);

        send(0, 8'hAA, 0, 0, 20);
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 30);
        check("glitch_state_idle", W'(st0), '0);
        send(0, 8'hBB, 0, 0, 10);
        send(0, 8'hCC, 0, 0, 20);
        check("glitch_packet", cfg0, 24'hCCBBAA);

        send(0, 8'h11, 0, 0, 10);
        send(0, 8'h22, 0, 3, 32);
        check("break_keeps_cfg", cfg0, 24'hCCBBAA);
        send(0, 8'h01, 0, 0, 0);
        send(0, 8'h02, 0, 0, 0);
        send(0, 8'h03, 0, 0, 20);
        check("after_break_packet", cfg0, 24'h030201);

        send(0, 8'h10, 0, 0, 10);
        send(0, 8'h20, 0, 0, TO + 5);
        send(0, 8'h30, 0, 0, 0);
        send(0, 8'h40, 0, 0, 0);
        send(0, 8'h50, 0, 0, 20);
        check("timeout_packet", cfg0, 24'h504030);

        send(0, 8'h61, 0, 0, 20);
        hold(0, 1'b0, CPB);
        hold(0, 1'b0, CPB);
        hold(0, 1'b1, CPB);
        hold(0, 1'b0, CPB / 2);
        set_line(0, 1'b1);
        rst0 = 1'b1;
        model_reset(0);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("midframe_reset_cfg", cfg0, '0);
          check("midframe_reset_pulses", W'({cv0, bv0, fe0, pe0}), '0);
        end
        rst0 = 1'b0;
        hold(0, 1'b1, 12 * CPB);
        check("post_reset_cfg", cfg0, '0);
        check("post_reset_state", W'(st0), '0);
        send(0, 8'h71, 0, 0, 0);
        send(0, 8'h72, 0, 0, 0);
        send(0, 8'h73, 0, 0, 20);
        check("post_reset_packet", cfg0, 24'h737271);

        rand_run(0, 30);
      end
      begin
        send(1, 8'hA1, 0, 0, 10);
        send(1, 8'h07, 1, 0, 10);
        send(1, 8'h07, 0, 0, 0);
        send(1, 8'h08, 0, 0, 0);
        send(1, 8'h09, 0, 0, 20);
        check("odd_parity_packet", cfg1, 24'h090807);
        rand_run(1, 30);
      end
    join

    repeat (40) @(negedge clk);
    check("dut0_events_left", W'(ev_q0.size()), '0);
    check("dut1_events_left", W'(ev_q1.size()), '0);
    check("dut0_cfg_left", W'(exp_q0.size()), '0);
    check("dut1_cfg_left", W'(exp_q1.size()), '0);
    check("dut0_final_cfg", cfg0, m_cfg[0]);
    check("dut1_final_cfg", cfg1, m_cfg[1]);
    check("dut0_final_state", W'(st0), '0);
    check("dut1_final_state", W'(st1), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
